// File: rtl/snn_pkg.sv
// Shared types and constants for the spike encoder: controller state encoding
// and the width of the timestep counter.
package snn_pkg;

  localparam int STEP_COUNT_WIDTH = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } enc_state_t;

endpackage

// File: rtl/spike_rate_channel.sv
// One rate-coding channel: a phase accumulator that emits a registered spike
// whenever adding the intensity carries out of the accumulator.
module spike_rate_channel #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] intensity,
  output logic                  spike
);

  logic [DATA_WIDTH-1:0] acc_reg;
  logic                  spike_reg;
  logic [DATA_WIDTH:0]   sum;

  // The carry bit of this sum is the spike; the low bits become the new phase.
  assign sum = {1'b0, acc_reg} + {1'b0, intensity};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_reg   <= '0;
      spike_reg <= 1'b0;
    end else if (step) begin
      acc_reg   <= sum[DATA_WIDTH-1:0];
      spike_reg <= sum[DATA_WIDTH];
    end else begin
      spike_reg <= 1'b0;
    end
  end

  assign spike = spike_reg;

endmodule

// File: rtl/spike_encoder.sv
// Rate-coded spike encoder: latches an intensity vector and, over NUM_STEPS
// timesteps, emits per-channel spikes at a rate proportional to intensity.
module spike_encoder
  import snn_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_STEPS    = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load_valid,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] load_data,
  output logic                               load_ready,
  input  logic                               step_en,
  output logic [NUM_CHANNELS-1:0]            spike_out,
  output logic                               busy,
  output logic                               done,
  output logic [STEP_COUNT_WIDTH-1:0]        step_count
);

  localparam logic [STEP_COUNT_WIDTH-1:0] LAST_COUNT = STEP_COUNT_WIDTH'(NUM_STEPS - 1);
  localparam logic [STEP_COUNT_WIDTH-1:0] ONE        = STEP_COUNT_WIDTH'(1);

  enc_state_t                          state_reg, state_next;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0]  intensity_reg;
  logic [STEP_COUNT_WIDTH-1:0]         step_count_reg;
  logic                                done_reg;
  logic                                accept;
  logic                                step_fire;
  logic                                last_step;

  always_comb begin
    state_next = state_reg;
    load_ready = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    step_fire  = 1'b0;
    last_step  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        load_ready = 1'b1;
        accept     = load_valid;
        if (load_valid) state_next = ST_RUN;
      end
      ST_RUN: begin
        busy      = 1'b1;
        step_fire = step_en;
        last_step = step_en && (step_count_reg == LAST_COUNT);
        if (last_step) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      intensity_reg  <= '0;
      step_count_reg <= '0;
      done_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= last_step;
      if (accept) begin
        intensity_reg  <= load_data;
        step_count_reg <= '0;
      end else if (step_fire) begin
        step_count_reg <= step_count_reg + ONE;
      end
    end
  end

  // Channels see the latched vector only, so load_data may change freely mid-window.
  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
    spike_rate_channel #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .clear    (accept),
      .step     (step_fire),
      .intensity(intensity_reg[gi*DATA_WIDTH +: DATA_WIDTH]),
      .spike    (spike_out[gi])
    );
  end

  assign done       = done_reg;
  assign step_count = step_count_reg;

endmodule

// File: doc/spike_encoder.md
SPIKE_ENCODER -- requirements
Module: spike_encoder

Interface
REQ-001 Parameter NUM_CHANNELS, default 4, number of spike output channels.
REQ-002 Parameter DATA_WIDTH, default 8, intensity width per channel.
REQ-003 Parameter NUM_STEPS, default 16, timesteps per encoding window, legal range 1..65535.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 load_valid  input  1  intensity vector offered.
REQ-007 load_data  input  NUM_CHANNELS*DATA_WIDTH  channel k intensity at bits [k*DATA_WIDTH +: DATA_WIDTH], unsigned.
REQ-008 load_ready  output  1  high when a vector can be accepted.
REQ-009 step_en  input  1  advances one timestep while running.
REQ-010 spike_out  output  NUM_CHANNELS  one-cycle spike pulses, bit k drives channel k.
REQ-011 busy  output  1  high while an encoding window is in progress.
REQ-012 done  output  1  one-cycle pulse marking the final timestep of a window.
REQ-013 step_count  output  16  number of timesteps completed in the current window.

Function
REQ-014 FSM has two states: IDLE and RUN.
REQ-015 load_ready is high exactly when state is IDLE; busy is high exactly when state is RUN.
REQ-016 A load is accepted when load_valid and load_ready are both high at a clock edge.
- On acceptance: latch all intensities, clear every channel phase accumulator to 0, clear step_count to 0, enter RUN.
REQ-017 In IDLE, step_en is ignored and spike_out is 0.
REQ-018 In RUN, each cycle with step_en high processes one timestep per channel:
- sum = acc + intensity, computed DATA_WIDTH+1 wide.
- acc <= sum[DATA_WIDTH-1:0].
- spike_out[k] <= sum[DATA_WIDTH].
REQ-019 spike_out is registered; the spike appears the cycle after the step_en edge and lasts exactly one cycle.
REQ-020 spike_out is 0 in every cycle not directly following a processed timestep.
REQ-021 In RUN, cycles with step_en low hold acc, step_count and state unchanged.
REQ-022 Each processed timestep increments step_count by 1.
REQ-023 On the timestep where step_count reaches NUM_STEPS:
- done pulses in the same cycle as that step's spike_out.
- state returns to IDLE.
REQ-024 Spike count per channel over a window equals floor(NUM_STEPS*I/2^DATA_WIDTH); I=0 never spikes.
REQ-025 load_valid during RUN is not accepted; the earliest acceptance is the cycle after done, when load_ready is high again.
REQ-026 Latched intensities are unaffected by load_data changes during RUN.

Reset
REQ-027 rst forces the following, overriding all other inputs, including mid-window:
- state IDLE, all acc and latched intensities 0, step_count 0.
- spike_out 0, done 0, busy 0, load_ready 1.
REQ-028 After rst deasserts, no spike or done is emitted until a new load is accepted and stepped.

Structure
REQ-029 FSM state encoding and the step_count width constant (16) reside in the shared package snn_pkg.
REQ-030 The per-channel accumulator is the sub-module spike_rate_channel, instantiated NUM_CHANNELS times by generate.
- Ports: clk, rst, clear, step, intensity, spike.

Verification
REQ-031 Load {255,128,64,0} (ch3..ch0 = 255,128,64,0), step_en held high for 16 cycles -> spike counts ch3=15, ch2=8, ch1=4, ch0=0; done in the 16th output cycle.
REQ-032 Intensity 128, step_en high -> spikes on output cycles 2,4,6,...,16 only; never two consecutive.
REQ-033 step_en toggled 1/0 every cycle -> same spike counts as REQ-031, spread over 32 cycles; step_count holds during gaps.
REQ-034 load_valid held high throughout a window with new data -> load_ready low during RUN; new vector accepted exactly the cycle after done.
REQ-035 rst asserted at step 7 -> next cycle: spike_out 0, step_count 0, busy 0, load_ready 1; no done emitted.
REQ-036 NUM_STEPS=1, intensity 200 -> no spike; done and busy-low one cycle after the single step.
